// File: rtl/bp_tlb_asid.sv
// ============================================================================
// Module   : bp_tlb_asid
// Purpose  : Fully-associative ASID-tagged TLB. It has a 1-cycle lookup, an
//            in-place or round-robin fill, and a selective ASID flush walk.
// Option   : BP_TLB_PERF_CNT_EN enables the saturating hit/miss counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bp_tlb_asid #(
  parameter int els_p         = 8,
  parameter int vtag_width_p  = 27,
  parameter int ptag_width_p  = 28,
  parameter int entry_width_p = 36,
  parameter int asid_width_p  = 9
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     translation_en_i,
  input  logic [asid_width_p-1:0]  asid_i,
  input  logic                     r_v_i,
  input  logic [vtag_width_p-1:0]  r_vtag_i,
  input  logic                     w_v_i,
  input  logic [vtag_width_p-1:0]  w_vtag_i,
  input  logic                     w_g_i,
  input  logic [entry_width_p-1:0] w_entry_i,
  input  logic                     flush_all_i,
  input  logic                     flush_asid_v_i,
  input  logic [asid_width_p-1:0]  flush_asid_i,
  output logic                     ready_o,
  output logic                     r_v_o,
  output logic [entry_width_p-1:0] r_entry_o,
  output logic                     miss_v_o,
  output logic [vtag_width_p-1:0]  miss_vtag_o,
  output logic [31:0]              hit_cnt_o,
  output logic [31:0]              miss_cnt_o
);

  localparam int IDX_W  = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int PASS_W = (vtag_width_p < ptag_width_p) ? vtag_width_p : ptag_width_p;

  typedef enum logic [0:0] {IDLE = 1'b0, WALK = 1'b1} state_e;

  state_e                   state_q, state_n;
  logic                     rst_done_q;
  logic [els_p-1:0]         valid_q;
  logic [els_p-1:0]         g_q;
  logic [vtag_width_p-1:0]  vtag_q  [els_p];
  logic [asid_width_p-1:0]  asid_q  [els_p];
  logic [entry_width_p-1:0] entry_q [els_p];
  logic [IDX_W-1:0]         victim_q;
  logic [IDX_W-1:0]         walk_idx_q;
  logic [asid_width_p-1:0]  flush_asid_q;

  logic                     flush_any;
  logic                     rd_acc;
  logic                     wr_acc;
  logic                     walk_start;
  logic                     r_hit;
  logic [entry_width_p-1:0] r_hit_entry;
  logic [entry_width_p-1:0] pass_entry;
  logic [els_p-1:0]         w_match;
  logic [els_p-1:0]         fill_oh;
  logic                     w_found;
  logic                     inv_found;
  logic                     use_victim;
  logic [IDX_W-1:0]         w_idx;
  logic [IDX_W-1:0]         inv_idx;
  logic [IDX_W-1:0]         fill_idx;
  logic                     walk_kill;

  // ready_o stays low until the first edge after reset release.
  assign ready_o    = rst_done_q & (state_q == IDLE);
  assign flush_any  = flush_all_i | flush_asid_v_i;
  assign rd_acc     = ready_o & r_v_i & ~flush_any;
  assign wr_acc     = ready_o & w_v_i & translation_en_i & ~flush_any;
  assign walk_start = ready_o & flush_asid_v_i & ~flush_all_i;
  assign walk_kill  = valid_q[walk_idx_q] & ~g_q[walk_idx_q]
                    & (asid_q[walk_idx_q] == flush_asid_q);

  always_comb begin
    r_hit       = 1'b0;
    r_hit_entry = '0;
    for (int i = 0; i < els_p; i++) begin
      if (!r_hit && valid_q[i] && (vtag_q[i] == r_vtag_i)
          && (g_q[i] || (asid_q[i] == asid_i))) begin
        r_hit       = 1'b1;
        r_hit_entry = entry_q[i];
      end
    end
  end

  always_comb begin
    pass_entry             = '0;
    pass_entry[PASS_W-1:0] = r_vtag_i[PASS_W-1:0];
  end

  // A global fill also claims same-vtag entries of other ASIDs, so that no
  // lookup can ever see two matches afterwards.
  always_comb begin
    w_match   = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int i = 0; i < els_p; i++) begin
      w_match[i] = valid_q[i] && (vtag_q[i] == w_vtag_i)
                   && (g_q[i] || w_g_i || (asid_q[i] == asid_i));
    end
    for (int i = 0; i < els_p; i++) begin
      if (!w_found && w_match[i]) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(i);
      end
      if (!inv_found && !valid_q[i]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
    end
    use_victim        = !w_found && !inv_found;
    fill_idx          = w_found ? w_idx : (inv_found ? inv_idx : victim_q);
    fill_oh           = '0;
    fill_oh[fill_idx] = 1'b1;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (walk_start) state_n = WALK;
      WALK:    if (walk_idx_q == IDX_W'(els_p - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush_all_i) state_n = IDLE;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      rst_done_q   <= 1'b0;
      valid_q      <= '0;
      victim_q     <= '0;
      walk_idx_q   <= '0;
      flush_asid_q <= '0;
    end else begin
      state_q    <= state_n;
      rst_done_q <= 1'b1;
      if (flush_all_i) begin
        valid_q    <= '0;
        victim_q   <= '0;
        walk_idx_q <= '0;
      end else if (state_q == WALK) begin
        if (walk_kill) valid_q[walk_idx_q] <= 1'b0;
        walk_idx_q <= walk_idx_q + IDX_W'(1);
      end else if (walk_start) begin
        flush_asid_q <= flush_asid_i;
        walk_idx_q   <= '0;
      end else if (wr_acc) begin
        valid_q <= (valid_q & ~w_match) | fill_oh;
        if (use_victim) victim_q <= victim_q + IDX_W'(1);
      end
    end
  end

  // Tag/payload storage needs no reset: valid_q qualifies every read.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      vtag_q[fill_idx]  <= w_vtag_i;
      asid_q[fill_idx]  <= asid_i;
      g_q[fill_idx]     <= w_g_i;
      entry_q[fill_idx] <= w_entry_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_v_o       <= 1'b0;
      miss_v_o    <= 1'b0;
      r_entry_o   <= '0;
      miss_vtag_o <= '0;
    end else begin
      r_v_o    <= rd_acc & (~translation_en_i | r_hit);
      miss_v_o <= rd_acc & translation_en_i & ~r_hit;
      if (rd_acc && !translation_en_i) begin
        r_entry_o <= pass_entry;
      end else if (rd_acc && r_hit) begin
        r_entry_o <= r_hit_entry;
      end
      if (rd_acc && translation_en_i && !r_hit) miss_vtag_o <= r_vtag_i;
    end
  end

`ifdef BP_TLB_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (r_v_o && (hit_cnt_q != 32'hFFFF_FFFF))    hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_v_o && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

`default_nettype wire
